ahb_lite_decoder_mux: RTL and testbench

AHB_LITE_DECODER_MUX -- requirements
Module: ahb_lite_decoder_mux

---
 rtl/ahb_lite_decoder_mux.sv | 128 ++++++++++++
 tb/tb_ahb_lite_decoder_mux.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and slave response multiplexer for three slaves,
// with an error-responding default slave and a saturating error counter.
module ahb_lite_decoder_mux #(
  parameter logic [2:0] S0_REGION = 3'b000,
  parameter logic [2:0] S1_REGION = 3'b001,
  parameter logic [2:0] S2_REGION = 3'b010
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic        HSEL_S0,
  output logic        HSEL_S1,
  output logic        HSEL_S2,
  input  logic [31:0] HRDATA_S0,
  input  logic [31:0] HRDATA_S1,
  input  logic [31:0] HRDATA_S2,
  input  logic        HREADY_RESP_S0,
  input  logic        HREADY_RESP_S1,
  input  logic        HREADY_RESP_S2,
  input  logic [1:0]  HRESP_S0,
  input  logic [1:0]  HRESP_S1,
  input  logic [1:0]  HRESP_S2,
  output logic [7:0]  ERR_COUNT
);

  typedef enum logic [1:0] {
    ST_OKAY,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Slaves take write data and transfer controls straight off the bus.
  logic unused_ctrl;
  assign unused_ctrl = ^{HADDR[28:0], HTRANS[0], HWRITE, HSIZE, HBURST, HPROT,
                         HMASTLOCK, HWDATA};

  logic       sel_s0, sel_s1, sel_s2, sel_def;
  logic       trans_active, start_err;
  logic [3:0] dsel_q, dsel_d;
  state_e     state_q, state_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       hready_def;
  logic [1:0] hresp_def;

  // Priority keeps the selects one-hot even if regions are overridden to overlap.
  assign sel_s0  = (HADDR[31:29] == S0_REGION);
  assign sel_s1  = (HADDR[31:29] == S1_REGION) && !sel_s0;
  assign sel_s2  = (HADDR[31:29] == S2_REGION) && !sel_s0 && !sel_s1;
  assign sel_def = !(sel_s0 || sel_s1 || sel_s2);

  assign HSEL_S0 = sel_s0;
  assign HSEL_S1 = sel_s1;
  assign HSEL_S2 = sel_s2;

  assign trans_active = HTRANS[1];
  assign start_err    = HREADY && sel_def && trans_active;

  always_comb begin
    dsel_d = dsel_q;
    if (HREADY) begin
      dsel_d = {sel_def, sel_s2, sel_s1, sel_s0};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OKAY: if (start_err) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      ST_ERR2: state_d = start_err ? ST_ERR1 : ST_OKAY;
      default: state_d = ST_OKAY;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_d == ST_ERR1) && (state_q != ST_ERR1) && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign hready_def = (state_q != ST_ERR1);
  assign hresp_def  = (state_q == ST_OKAY) ? 2'b00 : 2'b01;

  always_comb begin
    HRDATA = '0;
    HREADY = hready_def;
    HRESP  = hresp_def;
    if (dsel_q[0]) begin
      HRDATA = HRDATA_S0;
      HREADY = HREADY_RESP_S0;
      HRESP  = HRESP_S0;
    end else if (dsel_q[1]) begin
      HRDATA = HRDATA_S1;
      HREADY = HREADY_RESP_S1;
      HRESP  = HRESP_S1;
    end else if (dsel_q[2]) begin
      HRDATA = HRDATA_S2;
      HREADY = HREADY_RESP_S2;
      HRESP  = HRESP_S2;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q    <= 4'b1000;
      state_q   <= ST_OKAY;
      err_cnt_q <= '0;
    end else begin
      dsel_q    <= dsel_d;
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_COUNT = err_cnt_q;

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed bench for ahb_lite_decoder_mux: vector table plus wait-state,
// saturation and reset-abort sequences.
module tb_ahb_lite_decoder_mux;

  localparam logic [31:0] D0 = 32'h1111_0000;
  localparam logic [31:0] D1 = 32'hCAFE_F00D;
  localparam logic [31:0] D2 = 32'h3333_0002;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic        HSEL_S0, HSEL_S1, HSEL_S2;
  logic [31:0] HRDATA_S0, HRDATA_S1, HRDATA_S2;
  logic        HREADY_RESP_S0, HREADY_RESP_S1, HREADY_RESP_S2;
  logic [1:0]  HRESP_S0, HRESP_S1, HRESP_S2;
  logic [7:0]  ERR_COUNT;

  always #5 HCLK = ~HCLK;

  ahb_lite_decoder_mux #(
    .S0_REGION(3'b000),
    .S1_REGION(3'b001),
    .S2_REGION(3'b010)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .HSEL_S0(HSEL_S0), .HSEL_S1(HSEL_S1), .HSEL_S2(HSEL_S2),
    .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1), .HRDATA_S2(HRDATA_S2),
    .HREADY_RESP_S0(HREADY_RESP_S0), .HREADY_RESP_S1(HREADY_RESP_S1),
    .HREADY_RESP_S2(HREADY_RESP_S2),
    .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1), .HRESP_S2(HRESP_S2),
    .ERR_COUNT(ERR_COUNT)
  );

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  rdy;      // {S2,S1,S0} slave ready
    logic [1:0]  resp1;    // slave 1 response
    logic [2:0]  hsel_e;   // {S2,S1,S0}
    logic        rdy_e;
    logic [1:0]  resp_e;
    logic [31:0] rdata_e;
    logic [7:0]  cnt_e;
  } vec_t;

  vec_t vecs [16];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    logic found;

    vecs[0]  = '{32'h2000_0010, 2'b10, 3'b111, 2'b00, 3'b010, 1'b1, 2'b00, D1,    8'd0};
    vecs[1]  = '{32'h0000_0100, 2'b10, 3'b111, 2'b00, 3'b001, 1'b1, 2'b00, D0,    8'd0};
    vecs[2]  = '{32'h4000_0000, 2'b11, 3'b111, 2'b00, 3'b100, 1'b1, 2'b00, D2,    8'd0};
    vecs[3]  = '{32'hF000_0000, 2'b00, 3'b111, 2'b00, 3'b000, 1'b1, 2'b00, 32'h0, 8'd0};
    vecs[4]  = '{32'h6000_0000, 2'b01, 3'b111, 2'b00, 3'b000, 1'b1, 2'b00, 32'h0, 8'd0};
    vecs[5]  = '{32'h8000_0000, 2'b10, 3'b111, 2'b00, 3'b000, 1'b0, 2'b01, 32'h0, 8'd1};
    vecs[6]  = '{32'h8000_0000, 2'b10, 3'b111, 2'b00, 3'b000, 1'b1, 2'b01, 32'h0, 8'd1};
    vecs[7]  = '{32'h2000_0000, 2'b10, 3'b111, 2'b00, 3'b010, 1'b1, 2'b00, D1,    8'd1};
    vecs[8]  = '{32'hA000_0000, 2'b11, 3'b111, 2'b00, 3'b000, 1'b0, 2'b01, 32'h0, 8'd2};
    vecs[9]  = '{32'hA000_0000, 2'b11, 3'b111, 2'b00, 3'b000, 1'b1, 2'b01, 32'h0, 8'd2};
    vecs[10] = '{32'hC000_0000, 2'b10, 3'b111, 2'b00, 3'b000, 1'b0, 2'b01, 32'h0, 8'd3};
    vecs[11] = '{32'hC000_0000, 2'b10, 3'b111, 2'b00, 3'b000, 1'b1, 2'b01, 32'h0, 8'd3};
    vecs[12] = '{32'hE000_0000, 2'b00, 3'b111, 2'b00, 3'b000, 1'b1, 2'b00, 32'h0, 8'd3};
    vecs[13] = '{32'h2000_0004, 2'b10, 3'b111, 2'b01, 3'b010, 1'b1, 2'b01, D1,    8'd3};
    vecs[14] = '{32'h2000_0008, 2'b10, 3'b101, 2'b01, 3'b010, 1'b0, 2'b01, D1,    8'd3};
    vecs[15] = '{32'h2000_0008, 2'b10, 3'b111, 2'b00, 3'b010, 1'b1, 2'b00, D1,    8'd3};

    HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00;
    HWRITE = 1'b0; HSIZE = 3'b010; HBURST = '0; HPROT = 4'b0011;
    HMASTLOCK = 1'b0; HWDATA = 32'h5A5A_A5A5;
    HRDATA_S0 = D0; HRDATA_S1 = D1; HRDATA_S2 = D2;
    HREADY_RESP_S0 = 1'b1; HREADY_RESP_S1 = 1'b1; HREADY_RESP_S2 = 1'b1;
    HRESP_S0 = 2'b00; HRESP_S1 = 2'b00; HRESP_S2 = 2'b00;

    // Reset state
    @(posedge HCLK); #1;
    chk("rst_hready", {31'b0, HREADY}, 32'd1);
    chk("rst_hresp",  {30'b0, HRESP},  32'd0);
    chk("rst_hrdata", HRDATA,          32'd0);
    chk("rst_errcnt", {24'b0, ERR_COUNT}, 32'd0);

    @(negedge HCLK); HRESET = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge HCLK);
      HADDR = vecs[i].addr;
      HTRANS = vecs[i].trans;
      {HREADY_RESP_S2, HREADY_RESP_S1, HREADY_RESP_S0} = vecs[i].rdy;
      HRESP_S1 = vecs[i].resp1;
      #1;
      chk($sformatf("v%0d_hsel", i), {29'b0, HSEL_S2, HSEL_S1, HSEL_S0}, {29'b0, vecs[i].hsel_e});
      @(posedge HCLK); #1;
      chk($sformatf("v%0d_hready", i), {31'b0, HREADY}, {31'b0, vecs[i].rdy_e});
      chk($sformatf("v%0d_hresp", i),  {30'b0, HRESP},  {30'b0, vecs[i].resp_e});
      chk($sformatf("v%0d_hrdata", i), HRDATA, vecs[i].rdata_e);
      chk($sformatf("v%0d_errcnt", i), {24'b0, ERR_COUNT}, {24'b0, vecs[i].cnt_e});
    end

    // RAM read with two wait states while a ROM transfer is pending
    @(negedge HCLK);
    HADDR = 32'h2000_0010; HTRANS = 2'b10; HRESP_S1 = 2'b00;
    {HREADY_RESP_S2, HREADY_RESP_S1, HREADY_RESP_S0} = 3'b111;
    @(posedge HCLK); #1;
    HADDR = 32'h0000_0000; HTRANS = 2'b10; HREADY_RESP_S1 = 1'b0;
    #1;
    chk("ws_hsel_s0", {31'b0, HSEL_S0}, 32'd1);
    chk("ws_hready_c1", {31'b0, HREADY}, 32'd0);
    @(posedge HCLK); #1;
    chk("ws_hready_c2", {31'b0, HREADY}, 32'd0);
    chk("ws_dsel_hold", HRDATA, D1);
    @(posedge HCLK); #1;
    HREADY_RESP_S1 = 1'b1;
    #1;
    chk("ws_hready_c3", {31'b0, HREADY}, 32'd1);
    chk("ws_still_s1", HRDATA, D1);
    @(posedge HCLK); #1;
    chk("ws_rom_data", HRDATA, D0);
    chk("ws_rom_ready", {31'b0, HREADY}, 32'd1);

    // Saturation over 300 back-to-back unmapped NONSEQ transfers
    @(negedge HCLK); HRESET = 1'b1; HTRANS = 2'b00;
    @(negedge HCLK); HRESET = 1'b0; HADDR = 32'h8000_0000; HTRANS = 2'b10;
    repeat (19) @(posedge HCLK);
    #1;
    chk("sat_cnt10", {24'b0, ERR_COUNT}, 32'd10);
    chk("sat_err1_ready", {31'b0, HREADY}, 32'd0);
    repeat (581) @(posedge HCLK);
    #1;
    chk("sat_cnt_ff", {24'b0, ERR_COUNT}, 32'hFF);
    chk("sat_err2_resp", {30'b0, HRESP}, 32'd1);

    // Reset while in ERR1
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(posedge HCLK); #1;
      if (HREADY === 1'b0) found = 1'b1;
    end
    chk("err1_reached", {31'b0, found}, 32'd1);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    chk("rst_err1_hready", {31'b0, HREADY}, 32'd1);
    chk("rst_err1_hresp", {30'b0, HRESP}, 32'd0);
    chk("rst_err1_cnt", {24'b0, ERR_COUNT}, 32'd0);
    @(negedge HCLK); HRESET = 1'b0; HTRANS = 2'b00;
    @(posedge HCLK); #1;
    chk("post_rst_hready", {31'b0, HREADY}, 32'd1);
    chk("post_rst_hresp", {30'b0, HRESP}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
